// File: rtl/fifo16x8_ctrl_pkg.sv
// fifo16x8_ctrl shared definitions.
// Widths and sizes for the 16x8 RAM-backed FIFO controller.
package fifo16x8_ctrl_pkg;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int CAP   = 17;
    localparam int LW    = 5;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [LW-1:0] lvl_t;

    // RAM is full when it holds DEPTH words.
    function automatic logic ram_full(input lvl_t cnt);
        return cnt == lvl_t'(DEPTH);
    endfunction

endpackage

// File: rtl/fifo16x8_ctrl_if.sv
// fifo16x8_ctrl bus: push, pop, status and RAM ports.
// master = producer/consumer/RAM side, slave = controller.
interface fifo16x8_ctrl_if;
    import fifo16x8_ctrl_pkg::*;

    logic  in_valid;
    data_t in_data;
    logic  in_ready;
    logic  out_valid;
    data_t out_data;
    logic  out_ready;
    lvl_t  level;
    logic  almost_full;
    logic  ovf;
    logic  ram_wen;
    addr_t ram_w_addr;
    data_t ram_wr_data;
    logic  ram_ren;
    addr_t ram_r_addr;
    data_t ram_dout;

    modport master (
        output in_valid, in_data, out_ready, ram_dout,
        input  in_ready, out_valid, out_data, level, almost_full, ovf,
        input  ram_wen, ram_w_addr, ram_wr_data, ram_ren, ram_r_addr
    );

    modport slave (
        input  in_valid, in_data, out_ready, ram_dout,
        output in_ready, out_valid, out_data, level, almost_full, ovf,
        output ram_wen, ram_w_addr, ram_wr_data, ram_ren, ram_r_addr
    );

endinterface

// File: rtl/fifo16x8_ctrl.sv
// fifo16x8_ctrl: pointers, count and show-ahead stage for ram16x8.
// Capacity 17 = 16 RAM words + 1 output-stage word.
module fifo16x8_ctrl
    import fifo16x8_ctrl_pkg::*;
#(
    parameter int AF_LEVEL = 14
) (
    input  logic clock,
    input  logic rst,
    fifo16x8_ctrl_if.slave bus
);

    addr_t r_wptr;
    addr_t r_rptr;
    lvl_t  r_cnt;
    logic  r_ov;
    logic  r_ovf;

    logic  w_in_ready;
    logic  w_push;
    logic  w_fire;
    logic  w_ren;
    lvl_t  w_level;

    // Ready depends only on registered count; no pop-to-ready path.
    always_comb begin
        w_in_ready = ~ram_full(r_cnt);
        w_push     = bus.in_valid & w_in_ready & ~rst;
        w_fire     = r_ov & bus.out_ready;
        w_ren      = (r_cnt != '0) & (~r_ov | bus.out_ready) & ~rst;
        w_level    = r_cnt + {{(LW-1){1'b0}}, r_ov};
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_ov;
    assign bus.out_data    = bus.ram_dout;
    assign bus.level       = w_level;
    assign bus.almost_full = int'(w_level) >= AF_LEVEL;
    assign bus.ovf         = r_ovf;
    assign bus.ram_wen     = w_push;
    assign bus.ram_w_addr  = r_wptr;
    assign bus.ram_wr_data = bus.in_data;
    assign bus.ram_ren     = w_ren;
    assign bus.ram_r_addr  = r_rptr;

    // Pointer, count, output-stage and overflow state update.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ov   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + addr_t'(1);
            if (w_ren)  r_rptr <= r_rptr + addr_t'(1);
            r_cnt <= r_cnt + {{(LW-1){1'b0}}, w_push}
                           - {{(LW-1){1'b0}}, w_ren};
            if (w_ren)       r_ov <= 1'b1;
            else if (w_fire) r_ov <= 1'b0;
            r_ovf <= bus.in_valid & ~w_in_ready;
        end
    end

endmodule

// File: tb/tb_fifo16x8_ctrl.sv
// Testbench for fifo16x8_ctrl with a behavioural ram16x8 beside it.
// Queue-based reference model plus table and directed sequences.
module tb_fifo16x8_ctrl;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    fifo16x8_ctrl_if bus ();

    fifo16x8_ctrl #(.AF_LEVEL(14)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural ram16x8: registered read, dout held when ren = 0.
    logic [7:0] mem [16];
    always @(posedge clock) begin
        if (bus.ram_wen) mem[bus.ram_w_addr] <= bus.ram_wr_data;
        if (bus.ram_ren) bus.ram_dout <= mem[bus.ram_r_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) t=%0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: all held words in arrival order, plus whether
    // the head word has reached the output stage.
    logic [7:0] mq[$];
    bit         mvis;
    bit         movf;

    function automatic int m_ramcnt();
        return mq.size() - int'(mvis);
    endfunction

    function automatic bit m_ren(input bit orr);
        return (m_ramcnt() > 0) && (!mvis || orr);
    endfunction

    task automatic m_reset();
        mq.delete();
        mvis = 0;
        movf = 0;
    endtask

    logic       c_iv;
    logic [7:0] c_d;
    logic       c_or;

    task automatic drive(input logic iv, input logic [7:0] d,
                         input logic orr);
        @(negedge clock);
        rst           = 1'b0;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = orr;
        c_iv = iv;
        c_d  = d;
        c_or = orr;
        #1;
    endtask

    task automatic mcheck();
        bit rdy;
        rdy = m_ramcnt() != 16;
        chk("level",       int'(bus.level),       mq.size());
        chk("in_ready",    int'(bus.in_ready),    int'(rdy));
        chk("out_valid",   int'(bus.out_valid),   int'(mvis));
        chk("almost_full", int'(bus.almost_full), int'(mq.size() >= 14));
        chk("ovf",         int'(bus.ovf),         int'(movf));
        chk("ram_ren",     int'(bus.ram_ren),     int'(m_ren(c_or)));
        chk("ram_wen",     int'(bus.ram_wen),     int'(c_iv && rdy));
        if (mvis) chk("out_data", int'(bus.out_data), int'(mq[0]));
    endtask

    task automatic tick();
        bit rdy, push, pop, ren;
        @(posedge clock);
        rdy  = m_ramcnt() != 16;
        push = c_iv && rdy;
        pop  = mvis && c_or;
        ren  = m_ren(c_or);
        movf = c_iv && !rdy;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(c_d);
        if (ren)      mvis = 1;
        else if (pop) mvis = 0;
    endtask

    task automatic step(input logic iv, input logic [7:0] d,
                        input logic orr);
        drive(iv, d, orr);
        mcheck();
        tick();
    endtask

    task automatic do_reset(input logic iv);
        @(negedge clock);
        rst           = 1'b1;
        bus.in_valid  = iv;
        bus.in_data   = 8'h77;
        bus.out_ready = iv;
        @(posedge clock);
        m_reset();
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       orr;
        logic [4:0] lvl;
        logic       rdy;
        logic       ov;
        logic       ovf;
        logic       af;
    } vec_t;

    vec_t tbl [20];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        c_iv = 0;
        c_d  = 0;
        c_or = 0;
        m_reset();

        // Fill table: 17 accepted pushes, one dropped, then idle.
        for (int k = 0; k < 20; k++) begin
            int lv;
            lv = (k < 17) ? k : 17;
            tbl[k].iv  = (k < 18);
            tbl[k].d   = 8'(k + 1);
            tbl[k].orr = 1'b0;
            tbl[k].lvl = 5'(lv);
            tbl[k].rdy = (k < 17);
            tbl[k].ov  = (k >= 2);
            tbl[k].ovf = (k == 18);
            tbl[k].af  = (lv >= 14);
        end

        // Reset state.
        repeat (2) @(posedge clock);
        drive(1'b0, 8'h00, 1'b0);
        chk("rst_level",    int'(bus.level),       0);
        chk("rst_out_valid", int'(bus.out_valid),  0);
        chk("rst_in_ready", int'(bus.in_ready),    1);
        chk("rst_af",       int'(bus.almost_full), 0);
        chk("rst_ovf",      int'(bus.ovf),         0);
        chk("rst_ren",      int'(bus.ram_ren),     0);
        tick();

        // Reset then fill, table-driven.
        for (int k = 0; k < 18; k++) begin
            drive(tbl[k].iv, tbl[k].d, tbl[k].orr);
            chk("tbl_level",   int'(bus.level),       int'(tbl[k].lvl));
            chk("tbl_ready",   int'(bus.in_ready),    int'(tbl[k].rdy));
            chk("tbl_ovalid",  int'(bus.out_valid),   int'(tbl[k].ov));
            chk("tbl_ovf",     int'(bus.ovf),         int'(tbl[k].ovf));
            chk("tbl_af",      int'(bus.almost_full), int'(tbl[k].af));
            mcheck();
            tick();
        end
        for (int k = 18; k < 20; k++) begin
            drive(1'b0, 8'h00, 1'b0);
            chk("tbl_level",   int'(bus.level),       int'(tbl[k].lvl));
            chk("tbl_ready",   int'(bus.in_ready),    int'(tbl[k].rdy));
            chk("tbl_ovf",     int'(bus.ovf),         int'(tbl[k].ovf));
            chk("tbl_af",      int'(bus.almost_full), int'(tbl[k].af));
            mcheck();
            tick();
        end

        // Drain order: 0x01..0x11 on consecutive cycles.
        for (int k = 0; k < 17; k++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk("drain_valid", int'(bus.out_valid), 1);
            chk("drain_data",  int'(bus.out_data),  k + 1);
            mcheck();
            tick();
        end
        drive(1'b0, 8'h00, 1'b1);
        chk("drain_end_valid", int'(bus.out_valid), 0);
        chk("drain_end_level", int'(bus.level),     0);
        mcheck();
        tick();

        // Latency: push 0xA5 into empty FIFO.
        drive(1'b1, 8'hA5, 1'b0);
        chk("lat_wen", int'(bus.ram_wen), 1);
        mcheck();
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("lat_ren",    int'(bus.ram_ren),   1);
        chk("lat_valid0", int'(bus.out_valid), 0);
        mcheck();
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("lat_valid1", int'(bus.out_valid), 1);
        chk("lat_data",   int'(bus.out_data),  8'hA5);
        mcheck();
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("lat_stall_data", int'(bus.out_data), 8'hA5);
        mcheck();
        tick();
        step(1'b0, 8'h00, 1'b1);

        // Wrap-around: 40 words streamed with out_ready = 1.
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b1);
            chk("wrap_level_le2", int'(bus.level <= 5'd2), 1);
            mcheck();
            tick();
        end
        repeat (4) step(1'b0, 8'h00, 1'b1);
        chk("wrap_empty", int'(bus.level), 0);

        // Simultaneous push/pop at boundary.
        do_reset(1'b0);
        for (int k = 0; k < 17; k++) step(1'b1, 8'(8'h40 + k), 1'b0);
        drive(1'b1, 8'hEE, 1'b1);
        chk("bnd_ready0", int'(bus.in_ready),  0);
        chk("bnd_ren",    int'(bus.ram_ren),   1);
        chk("bnd_valid",  int'(bus.out_valid), 1);
        mcheck();
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("bnd_ready1", int'(bus.in_ready), 1);
        chk("bnd_level",  int'(bus.level),    16);
        chk("bnd_ovf",    int'(bus.ovf),      1);
        mcheck();
        tick();

        // Reset mid-stream at level 9 with in_valid high.
        do_reset(1'b0);
        for (int k = 0; k < 9; k++) step(1'b1, 8'(8'h90 + k), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk("mid_level9", int'(bus.level), 9);
        tick();
        do_reset(1'b1);
        drive(1'b0, 8'h00, 1'b0);
        chk("mid_level0", int'(bus.level),     0);
        chk("mid_valid0", int'(bus.out_valid), 0);
        mcheck();
        tick();
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h3D, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk("mid_first", int'(bus.out_data), 8'h3C);
        mcheck();
        tick();

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            logic iv, orr;
            iv  = ($urandom_range(0, 3) != 0);
            orr = (k % 200 < 100) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
            step(iv, 8'($urandom_range(0, 255)), orr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo16x8_ctrl.md
# fifo16x8_ctrl

Synchronous FIFO controller that sits directly upstream of the 16x8 RAM (`ram16x8`). It owns the write and read pointers and the occupancy count, and drives the RAM's write/read ports. It presents a valid/ready push interface to the producer and a valid/ready pop interface to the consumer. The RAM's 1-cycle registered read is absorbed into a show-ahead output stage, so pop throughput is one word per cycle.

## Interface
- `AF_LEVEL`, default 14: `almost_full` asserts when `level >= AF_LEVEL`; legal range 1..17.
- `clock` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset. Also wired to the RAM's `rst`.
- `in_valid` in 1: producer has a word.
- `in_data` in 8: producer word.
- `in_ready` out 1: word accepted on this edge when `in_valid & in_ready`.
- `out_valid` out 1: `out_data` holds the head word.
- `out_data` out 8: head word, taken from `ram_dout`.
- `out_ready` in 1: consumer takes the word on this edge when `out_valid & out_ready`.
- `level` out 5: total words held, 0..17.
- `almost_full` out 1: see `AF_LEVEL`.
- `ovf` out 1: 1-cycle pulse when `in_valid & ~in_ready`; the word is dropped.
- `ram_wen` out 1, `ram_w_addr` out 4, `ram_wr_data` out 8: RAM write port.
- `ram_ren` out 1, `ram_r_addr` out 4: RAM read port.
- `ram_dout` in 8: RAM registered read data.

## Operation
- **State:**
  - `wptr[3:0]` and `rptr[3:0]`; both wrap 15→0 by natural 4-bit overflow.
  - `ram_cnt[4:0]` counts words in the RAM, 0..16.
  - `ov_q` is the output-stage valid flag.
- **Push:**
  - `in_ready = (ram_cnt != 16)`.
  - `push = in_valid & in_ready`.
  - Combinational outputs: `ram_wen = push`, `ram_w_addr = wptr`, `ram_wr_data = in_data`.
  - `wptr` increments on `push`.
- **Pop/refill:**
  - `fire_out = ov_q & out_ready`.
  - `ram_ren = (ram_cnt != 0) & (~ov_q | out_ready)`.
  - `ram_r_addr = rptr`; `rptr` increments on `ram_ren`.
  - Next `ov_q`: 1 if `ram_ren`; else 0 if `fire_out`; else hold.
  - `out_valid = ov_q`, `out_data = ram_dout`. The RAM holds `dout` when `ren` = 0, so the data is stable while stalled.
- **Counts:**
  - `ram_cnt` next = `ram_cnt + push - ram_ren`.
  - `level = ram_cnt + ov_q`, combinational.
- **Capacity:** 17 words total (16 in the RAM plus 1 in the output stage).
- **Read/write collision:** the RAM is never read at an address being written in the same cycle with stale intent.
  - `ram_ren` requires `ram_cnt >= 1`, so `rptr` always points at an already-written word.
  - A write at `wptr == rptr` only occurs when `ram_cnt == 0`, which blocks `ren`.
- **Simultaneous push and pop:** allowed in every state, including `ram_cnt == 16` with a pop.
  - `in_ready` depends only on the registered `ram_cnt`. A pop does not free space until the next cycle; no combinational ready-from-ready path.
- **Reset:**
  - `wptr = rptr = 0`, `ram_cnt = 0`, `ov_q = 0`.
  - Outputs during/after reset: `out_valid = 0`, `level = 0`, `in_ready = 1`, `almost_full = 0` (with default `AF_LEVEL`), `ovf = 0`, `ram_wen = 0`, `ram_ren = 0`.
  - `ram_wen` and `ram_ren` are forced 0 while `rst` = 1.
  - Reset mid-operation discards all contents. Any push/pop presented in the reset cycle is ignored.

## Timing
- **Write-to-output latency** (empty FIFO):
  - Push at edge N.
  - `ram_ren` asserted in cycle N+1.
  - `out_valid = 1` with data after edge N+2.
- **Streaming:** continuous push with `out_ready = 1` yields one output per cycle after the initial 2-cycle fill.
- **`in_ready`:** depends only on registered state. `out_valid` / `out_data` are stable while `out_ready = 0`.
- **`ovf`:** registered, asserts the cycle after the dropped attempt.

## Structure
- **Shared include `fifo16x8_defs`:**
  - `DW = 8`, `AW = 4`, `DEPTH = 16`, `CAP = 17`.
  - Level width 5.
- **No sub-module inside.** The block is instantiated beside `ram16x8` in a `sync_fifo16x8` wrapper that connects the `ram_*` ports and shares `clock` / `rst`.

## Test plan
- **Reset then fill:** after reset, push 0x01..0x11 (17 words) with `out_ready = 0` → `in_ready` drops once `ram_cnt = 16`; `level = 17`; `almost_full` from level 14; an 18th push gives `ovf` = 1 for one cycle and is dropped.
- **Drain order:** from full, set `out_ready = 1` → `out_data` = 0x01..0x11 on 17 consecutive cycles; then `out_valid = 0`, `level = 0`.
- **Latency:** into an empty FIFO, push 0xA5 at edge N → `ram_ren` in cycle N+1; `out_valid` with `out_data = 0xA5` after edge N+2.
- **Wrap-around:** push/pop 40 words continuously with `out_ready = 1` → output equals the input sequence; pointers wrap twice; `level` stays ≤ 2.
- **Simultaneous at boundary:** with `ram_cnt = 16` and `out_valid = 1`, assert `in_valid` and `out_ready` → pop occurs, push refused (`in_ready = 0`); the next cycle `in_ready = 1`.
- **Reset mid-stream:** with `level = 9`, assert `rst` for 1 cycle with `in_valid` high → `level = 0`, `out_valid = 0`; the next push of 0x3C emerges first.
